// File: rtl/config_regfile_pkg.sv
// rtl/config_regfile_pkg.sv - address map, field positions and reset constants for config_regfile
package config_regfile_pkg;

  // Byte offsets of the control registers inside page 0x000
  localparam logic [7:0] OFF_FB_BASE   = 8'h00;
  localparam logic [7:0] OFF_VB_BASE   = 8'h04;
  localparam logic [7:0] OFF_CTRL      = 8'h08;
  localparam logic [7:0] OFF_STATUS    = 8'h0C;
  localparam logic [7:0] OFF_FRAME_CNT = 8'h10;

  // 256-byte pages (address bits above 7) holding the word arrays
  localparam logic [23:0] PAGE_REGS  = 24'h0;
  localparam logic [23:0] PAGE_MV    = 24'h1;
  localparam logic [23:0] PAGE_MVP   = 24'h2;
  localparam logic [23:0] PAGE_LIGHT = 24'h3;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int STATUS_BUSY_BIT   = 0;
  localparam int STATUS_DONE_BIT   = 1;
  localparam int STATUS_ERR_BIT    = 2;

  localparam logic [31:0] VB_BASE_RESET = 32'h0030_0000;

  // Array index width: one page holds 64 words
  localparam int IDX_W = 6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } render_state_t;

endpackage

// File: rtl/config_regfile_if.sv
// rtl/config_regfile_if.sv - register bus bundle between host and config_regfile
interface config_regfile_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, write, writedata, read,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/config_shadow_bank.sv
// rtl/config_shadow_bank.sv - N-word shadow array with a committed active copy
module config_shadow_bank
  import config_regfile_pkg::*;
#(
  parameter int N      = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [IDX_W-1:0]         i_wr_idx,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [IDX_W-1:0]         i_rd_idx,
  input  logic                     i_commit,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic [N-1:0][DATA_W-1:0] o_active
);

  logic [N-1:0][DATA_W-1:0] r_shadow;
  logic [N-1:0][DATA_W-1:0] r_active;

  // Shadow takes bus writes (out-of-range indices match no word); active copies shadow on commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(i))) r_shadow[i] <= i_wr_data;
      end
      if (i_commit) r_active <= r_shadow;
    end
  end

  // Read mux over the shadow words; indices past N read as zero
  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i_rd_idx == IDX_W'(i)) o_rd_data = r_shadow[i];
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/config_regfile.sv
// rtl/config_regfile.sv - render configuration register file with shadow/active commit on START
module config_regfile
  import config_regfile_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int MAT_WORDS   = 16,
  parameter int LIGHT_WORDS = 3,
  parameter int BASE_W      = 26
) (
  input  logic                               clk,
  input  logic                               reset,
  config_regfile_if.slave                    bus,
  output logic [MAT_WORDS-1:0][DATA_W-1:0]   MV,
  output logic [MAT_WORDS-1:0][DATA_W-1:0]   MVP,
  output logic [LIGHT_WORDS-1:0][DATA_W-1:0] lighting,
  output logic [BASE_W-1:0]                  frame_buffer_base,
  output logic [BASE_W-1:0]                  vertex_buffer_base,
  output logic                               render_start,
  input  logic                               render_done,
  output logic                               busy,
  output logic                               irq
);

  render_state_t     r_state, w_state_next;
  logic [BASE_W-1:0] r_fb_shadow, r_vb_shadow, r_fb_active, r_vb_active;
  logic              r_irq_en, r_done, r_err, r_render_start, r_irq, r_rdvalid;
  logic [DATA_W-1:0] r_frame_cnt, r_readdata, w_rd_data;
  logic [DATA_W-1:0] w_mv_rd, w_mvp_rd, w_light_rd;

  // Address is split into page / word index / register offset; arrays require word alignment
  logic [31:0]      w_addr32;
  logic [23:0]      w_page;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_off;
  logic             w_aligned;
  assign w_addr32  = 32'(bus.address);
  assign w_page    = w_addr32[31:8];
  assign w_idx     = w_addr32[7:2];
  assign w_off     = w_addr32[7:0];
  assign w_aligned = (w_addr32[1:0] == 2'b00);

  logic w_wr_regs, w_wr_fb, w_wr_vb, w_wr_ctrl, w_wr_status;
  logic w_wr_mv, w_wr_mvp, w_wr_light;
  assign w_wr_regs   = bus.write && (w_page == PAGE_REGS);
  assign w_wr_fb     = w_wr_regs && (w_off == OFF_FB_BASE);
  assign w_wr_vb     = w_wr_regs && (w_off == OFF_VB_BASE);
  assign w_wr_ctrl   = w_wr_regs && (w_off == OFF_CTRL);
  assign w_wr_status = w_wr_regs && (w_off == OFF_STATUS);
  assign w_wr_mv     = bus.write && w_aligned && (w_page == PAGE_MV);
  assign w_wr_mvp    = bus.write && w_aligned && (w_page == PAGE_MVP);
  assign w_wr_light  = bus.write && w_aligned && (w_page == PAGE_LIGHT);

  // START is judged against the busy state before this edge, so a same-cycle render_done
  // cannot make a START acceptable
  logic w_start_req, w_start_ok, w_start_rej, w_done_ok;
  assign w_start_req = w_wr_ctrl && bus.writedata[CTRL_START_BIT];
  assign w_start_ok  = w_start_req && (r_state == ST_IDLE);
  assign w_start_rej = w_start_req && (r_state == ST_BUSY);
  assign w_done_ok   = render_done && (r_state == ST_BUSY);

  // Frame-in-flight state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next frame state: accepted START opens a frame, render_done closes it
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_next = ST_BUSY;
      ST_BUSY: if (w_done_ok)  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Base address shadows and their active copies
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fb_shadow <= '0;
      r_vb_shadow <= BASE_W'(VB_BASE_RESET);
      r_fb_active <= '0;
      r_vb_active <= BASE_W'(VB_BASE_RESET);
    end else begin
      if (w_wr_fb) r_fb_shadow <= bus.writedata[BASE_W-1:0];
      if (w_wr_vb) r_vb_shadow <= bus.writedata[BASE_W-1:0];
      if (w_start_ok) begin
        r_fb_active <= r_fb_shadow;
        r_vb_active <= r_vb_shadow;
      end
    end
  end

  // Control/status flags, frame counter, start pulse and registered interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en       <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_frame_cnt    <= '0;
      r_render_start <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      r_render_start <= w_start_ok;
      r_irq          <= r_done && r_irq_en;
      if (w_wr_ctrl) r_irq_en <= bus.writedata[CTRL_IRQ_EN_BIT];
      if (w_done_ok)                                        r_done <= 1'b1;
      else if (w_wr_status && bus.writedata[STATUS_DONE_BIT]) r_done <= 1'b0;
      if (w_start_rej)                                      r_err <= 1'b1;
      else if (w_wr_status && bus.writedata[STATUS_ERR_BIT])  r_err <= 1'b0;
      if (w_done_ok) r_frame_cnt <= r_frame_cnt + DATA_W'(1);
    end
  end

  // Read data mux over pre-edge state, so a same-cycle write is not visible
  always_comb begin
    w_rd_data = '0;
    if (w_aligned) begin
      case (w_page)
        PAGE_REGS: begin
          case (w_off)
            OFF_FB_BASE:   w_rd_data = DATA_W'(r_fb_shadow);
            OFF_VB_BASE:   w_rd_data = DATA_W'(r_vb_shadow);
            OFF_CTRL:      w_rd_data[CTRL_IRQ_EN_BIT] = r_irq_en;
            OFF_STATUS: begin
              w_rd_data[STATUS_BUSY_BIT] = (r_state == ST_BUSY);
              w_rd_data[STATUS_DONE_BIT] = r_done;
              w_rd_data[STATUS_ERR_BIT]  = r_err;
            end
            OFF_FRAME_CNT: w_rd_data = r_frame_cnt;
            default:       w_rd_data = '0;
          endcase
        end
        PAGE_MV:    w_rd_data = w_mv_rd;
        PAGE_MVP:   w_rd_data = w_mvp_rd;
        PAGE_LIGHT: w_rd_data = w_light_rd;
        default:    w_rd_data = '0;
      endcase
    end
  end

  // One-cycle read response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
      r_rdvalid  <= 1'b0;
    end else begin
      r_rdvalid <= bus.read;
      if (bus.read) r_readdata <= w_rd_data;
    end
  end

  config_shadow_bank #(.N(MAT_WORDS), .DATA_W(DATA_W)) u_mv_bank (
    .clk(clk), .reset(reset), .i_wr_en(w_wr_mv), .i_wr_idx(w_idx),
    .i_wr_data(bus.writedata), .i_rd_idx(w_idx), .i_commit(w_start_ok),
    .o_rd_data(w_mv_rd), .o_active(MV)
  );

  config_shadow_bank #(.N(MAT_WORDS), .DATA_W(DATA_W)) u_mvp_bank (
    .clk(clk), .reset(reset), .i_wr_en(w_wr_mvp), .i_wr_idx(w_idx),
    .i_wr_data(bus.writedata), .i_rd_idx(w_idx), .i_commit(w_start_ok),
    .o_rd_data(w_mvp_rd), .o_active(MVP)
  );

  config_shadow_bank #(.N(LIGHT_WORDS), .DATA_W(DATA_W)) u_light_bank (
    .clk(clk), .reset(reset), .i_wr_en(w_wr_light), .i_wr_idx(w_idx),
    .i_wr_data(bus.writedata), .i_rd_idx(w_idx), .i_commit(w_start_ok),
    .o_rd_data(w_light_rd), .o_active(lighting)
  );

  assign frame_buffer_base  = r_fb_active;
  assign vertex_buffer_base = r_vb_active;
  assign render_start       = r_render_start;
  assign busy               = (r_state == ST_BUSY);
  assign irq                = r_irq;
  assign bus.readdata       = r_readdata;
  assign bus.readdatavalid  = r_rdvalid;

endmodule

// File: tb/tb_config_regfile.sv
// tb/tb_config_regfile.sv - randomized self-checking bench for config_regfile
module tb_config_regfile;
  localparam int DATA_W = 32, ADDR_W = 16, MAT_WORDS = 16, LIGHT_WORDS = 3, BASE_W = 26;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  config_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [MAT_WORDS-1:0][DATA_W-1:0]   MV, MVP;
  logic [LIGHT_WORDS-1:0][DATA_W-1:0] lighting;
  logic [BASE_W-1:0]                  frame_buffer_base, vertex_buffer_base;
  logic render_start, render_done, busy, irq;

  config_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAT_WORDS(MAT_WORDS),
                   .LIGHT_WORDS(LIGHT_WORDS), .BASE_W(BASE_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .MV(MV), .MVP(MVP), .lighting(lighting),
    .frame_buffer_base(frame_buffer_base), .vertex_buffer_base(vertex_buffer_base),
    .render_start(render_start), .render_done(render_done), .busy(busy), .irq(irq)
  );

  int total = 0;
  int bad = 0;

  // Reference model: register contents as plain arrays and flags
  logic [31:0] m_mv_sh[16], m_mv_act[16], m_mvp_sh[16], m_mvp_act[16];
  logic [31:0] m_li_sh[3], m_li_act[3];
  logic [31:0] m_fb_sh, m_vb_sh, m_fb_act, m_vb_act, m_fcnt;
  logic        m_busy, m_done, m_err, m_irq_en, m_start_exp;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_mv_sh[i] = 0; m_mv_act[i] = 0; m_mvp_sh[i] = 0; m_mvp_act[i] = 0; end
    for (int i = 0; i < 3; i++) begin m_li_sh[i] = 0; m_li_act[i] = 0; end
    m_fb_sh = 0; m_fb_act = 0; m_vb_sh = 32'h300000; m_vb_act = 32'h300000;
    m_fcnt = 0; m_busy = 0; m_done = 0; m_err = 0; m_irq_en = 0; m_start_exp = 0;
  endtask

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (a == 32'h0)  return m_fb_sh;
    if (a == 32'h4)  return m_vb_sh;
    if (a == 32'h8)  return {30'd0, m_irq_en, 1'b0};
    if (a == 32'hC)  return {29'd0, m_err, m_done, m_busy};
    if (a == 32'h10) return m_fcnt;
    if (a % 4 != 0) return 0;
    if (a >= 32'h100 && a < 32'h100 + 4*16) return m_mv_sh[(a - 32'h100) / 4];
    if (a >= 32'h200 && a < 32'h200 + 4*16) return m_mvp_sh[(a - 32'h200) / 4];
    if (a >= 32'h300 && a < 32'h300 + 4*3)  return m_li_sh[(a - 32'h300) / 4];
    return 0;
  endfunction

  task automatic model_write(logic [31:0] a, logic [31:0] d);
    if (a == 32'h0) m_fb_sh = d % (32'd1 << 26);
    else if (a == 32'h4) m_vb_sh = d % (32'd1 << 26);
    else if (a == 32'h8) begin
      m_irq_en = d[1];
      if (d[0]) begin
        if (m_busy) m_err = 1;
        else begin
          m_mv_act = m_mv_sh; m_mvp_act = m_mvp_sh; m_li_act = m_li_sh;
          m_fb_act = m_fb_sh; m_vb_act = m_vb_sh;
          m_busy = 1; m_start_exp = 1;
        end
      end
    end else if (a == 32'hC) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end else if (a % 4 == 0) begin
      if (a >= 32'h100 && a < 32'h100 + 4*16) m_mv_sh[(a - 32'h100) / 4] = d;
      else if (a >= 32'h200 && a < 32'h200 + 4*16) m_mvp_sh[(a - 32'h200) / 4] = d;
      else if (a >= 32'h300 && a < 32'h300 + 4*3) m_li_sh[(a - 32'h300) / 4] = d;
    end
  endtask

  // Applied after any same-cycle write so a DONE set beats a DONE clear
  task automatic model_done();
    if (m_busy) begin m_busy = 0; m_done = 1; m_fcnt = m_fcnt + 1; end
  endtask

  task automatic bus_write(logic [15:0] a, logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    m_start_exp = 0;
    model_write({16'd0, a}, d);
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(logic [15:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.readdata; v = bus.readdatavalid;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    render_done = 1'b1; m_start_exp = 0;
    model_done();
    @(negedge clk);
    render_done = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
    total++; if (render_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0h want=0", render_start); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0h want=0", irq); end
    total++; if (bus.readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_rdvalid got=%0h want=0", bus.readdatavalid); end
    total++; if (bus.readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%0h want=0", bus.readdata); end
    total++; if (vertex_buffer_base !== 26'h300000) begin bad++; $display("FAIL reset_vb got=%0h want=300000", vertex_buffer_base); end
    total++; if (frame_buffer_base !== 26'h0) begin bad++; $display("FAIL reset_fb got=%0h want=0", frame_buffer_base); end
    total++; if (MV !== '0 || MVP !== '0 || lighting !== '0) begin bad++; $display("FAIL reset_arrays got=nonzero want=0"); end
    reset = 1'b0;
  endtask

  task automatic test_shadow_write();
    logic [31:0] d; logic v;
    bus_write(16'h010C, 32'h3F800000);
    bus_read(16'h010C, d, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL shadow_rdvalid got=%0h want=1", v); end
    total++; if (d !== 32'h3F800000) begin bad++; $display("FAIL shadow_rdata got=%0h want=3f800000", d); end
    total++; if (MV[3] !== 32'h0) begin bad++; $display("FAIL shadow_mv3_active got=%0h want=0", MV[3]); end
    @(negedge clk);
    total++; if (bus.readdatavalid !== 1'b0) begin bad++; $display("FAIL shadow_rdvalid_drop got=%0h want=0", bus.readdatavalid); end
  endtask

  task automatic test_start();
    bus_write(16'h0000, 32'hF123_4567);
    bus_write(16'h0004, 32'h00AB_CDEF);
    bus_write(16'h0008, 32'h1);
    total++; if (render_start !== 1'b1) begin bad++; $display("FAIL start_pulse got=%0h want=1", render_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0h want=1", busy); end
    total++; if (MV[3] !== 32'h3F800000) begin bad++; $display("FAIL start_mv3 got=%0h want=3f800000", MV[3]); end
    total++; if (frame_buffer_base !== 26'h1234567) begin bad++; $display("FAIL start_fb got=%0h want=1234567", frame_buffer_base); end
    total++; if (vertex_buffer_base !== 26'h0ABCDEF) begin bad++; $display("FAIL start_vb got=%0h want=abcdef", vertex_buffer_base); end
    @(negedge clk);
    total++; if (render_start !== 1'b0) begin bad++; $display("FAIL start_pulse_len got=%0h want=0", render_start); end
  endtask

  task automatic test_busy_reject();
    logic [31:0] d; logic v;
    bus_write(16'h0200, 32'h5);
    bus_write(16'h0008, 32'h1);
    total++; if (render_start !== 1'b0) begin bad++; $display("FAIL reject_pulse got=%0h want=0", render_start); end
    total++; if (MVP[0] !== 32'h0) begin bad++; $display("FAIL reject_mvp0 got=%0h want=0", MVP[0]); end
    bus_read(16'h000C, d, v);
    total++; if (d !== 32'h5 || v !== 1'b1) begin bad++; $display("FAIL reject_status got=%0h/%0h want=5/1", d, v); end
  endtask

  task automatic test_done_irq();
    logic [31:0] d; logic v;
    bus_write(16'h0008, 32'h2);
    pulse_done();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy got=%0h want=0", busy); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL done_irq got=%0h want=1", irq); end
    bus_read(16'h000C, d, v);
    total++; if (d[1] !== 1'b1 || d[0] !== 1'b0) begin bad++; $display("FAIL done_status got=%0h want=bit1 set bit0 clear", d); end
    bus_read(16'h0010, d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL done_fcnt got=%0h want=1", d); end
    bus_write(16'h000C, 32'h2);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL done_irq_clear got=%0h want=0", irq); end
  endtask

  task automatic test_collisions();
    logic [31:0] d, old_fb; logic v;
    bus_write(16'h000C, 32'h4);
    bus_write(16'h0008, 32'h1);
    // DONE clear and DONE set in the same cycle
    @(negedge clk);
    bus.address = 16'h000C; bus.writedata = 32'h2; bus.write = 1'b1; render_done = 1'b1;
    model_write(32'hC, 32'h2); model_done();
    @(negedge clk);
    bus.write = 1'b0; render_done = 1'b0;
    bus_read(16'h000C, d, v);
    total++; if (d !== model_read(32'hC)) begin bad++; $display("FAIL coll_done_wins got=%0h want=%0h", d, model_read(32'hC)); end
    // START in the cycle render_done closes the frame
    bus_write(16'h0008, 32'h1);
    @(negedge clk);
    bus.address = 16'h0008; bus.writedata = 32'h1; bus.write = 1'b1; render_done = 1'b1;
    m_start_exp = 0; model_write(32'h8, 32'h1); model_done();
    @(negedge clk);
    bus.write = 1'b0; render_done = 1'b0;
    total++; if (render_start !== 1'b0) begin bad++; $display("FAIL coll_start_rej got=%0h want=0", render_start); end
    bus_read(16'h000C, d, v);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL coll_status got=%0h want=6", d); end
    // Read and write of the same register in one cycle
    old_fb = model_read(32'h0);
    @(negedge clk);
    bus.address = 16'h0000; bus.writedata = 32'h0155_AA55; bus.write = 1'b1; bus.read = 1'b1;
    model_write(32'h0, 32'h0155_AA55);
    @(negedge clk);
    bus.write = 1'b0; bus.read = 1'b0;
    total++; if (bus.readdata !== old_fb) begin bad++; $display("FAIL coll_rw_old got=%0h want=%0h", bus.readdata, old_fb); end
    bus_read(16'h0000, d, v);
    total++; if (d !== 32'h0155_AA55) begin bad++; $display("FAIL coll_rw_new got=%0h want=155aa55", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic v;
    bus_write(16'h0340, 32'hDEAD_BEEF);
    bus_read(16'h0340, d, v);
    total++; if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL unmapped_read got=%0h/%0h want=0/1", d, v); end
    for (int i = 0; i < 3; i++) begin
      bus_read(16'(16'h0300 + 4*i), d, v);
      total++; if (d !== m_li_sh[i]) begin bad++; $display("FAIL unmapped_light%0d got=%0h want=%0h", i, d, m_li_sh[i]); end
    end
  endtask

  task automatic test_random(int n);
    logic [31:0] d, exp; logic v;
    logic [15:0] a;
    int op;
    for (int k = 0; k < n; k++) begin
      op = $urandom_range(0, 7);
      m_start_exp = 0;
      case (op)
        0: bus_write(16'(16'h0100 + 4*$urandom_range(0, 17)), $urandom);
        1: bus_write(16'(16'h0200 + 4*$urandom_range(0, 17)), $urandom);
        2: bus_write(16'(16'h0300 + 4*$urandom_range(0, 4)), $urandom);
        3: bus_write(16'(4*$urandom_range(0, 1)), $urandom);
        4: bus_write(16'h0008, 32'($urandom_range(0, 3)));
        5: bus_write(16'h000C, 32'($urandom_range(0, 7)));
        6: pulse_done();
        default: begin
          case ($urandom_range(0, 3))
            0: a = 16'(4*$urandom_range(0, 6));
            1: a = 16'(16'h0100 + 4*$urandom_range(0, 17));
            2: a = 16'(16'h0200 + 4*$urandom_range(0, 17));
            default: a = 16'(16'h0300 + 4*$urandom_range(0, 4));
          endcase
          exp = model_read({16'd0, a});
          bus_read(a, d, v);
          total++; if (d !== exp || v !== 1'b1) begin bad++; $display("FAIL rnd_read a=%0h got=%0h/%0h want=%0h/1", a, d, v, exp); end
        end
      endcase
      total++; if (render_start !== m_start_exp) begin bad++; $display("FAIL rnd_start op=%0d got=%0h want=%0h", op, render_start, m_start_exp); end
      @(negedge clk);
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy got=%0h want=%0h", busy, m_busy); end
      total++; if (irq !== (m_done & m_irq_en)) begin bad++; $display("FAIL rnd_irq got=%0h want=%0h", irq, m_done & m_irq_en); end
      total++; if (32'(frame_buffer_base) !== m_fb_act || 32'(vertex_buffer_base) !== m_vb_act) begin
        bad++; $display("FAIL rnd_bases got=%0h/%0h want=%0h/%0h", frame_buffer_base, vertex_buffer_base, m_fb_act, m_vb_act);
      end
      for (int i = 0; i < 16; i++) begin
        total++; if (MV[i] !== m_mv_act[i] || MVP[i] !== m_mvp_act[i]) begin
          bad++; $display("FAIL rnd_mat%0d got=%0h/%0h want=%0h/%0h", i, MV[i], MVP[i], m_mv_act[i], m_mvp_act[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        total++; if (lighting[i] !== m_li_act[i]) begin bad++; $display("FAIL rnd_light%0d got=%0h want=%0h", i, lighting[i], m_li_act[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d; logic v;
    if (m_busy) pulse_done();
    bus_write(16'h0104, 32'h1234_5678);
    bus_write(16'h0008, 32'h1);
    total++; if (render_start !== 1'b1) begin bad++; $display("FAIL mid_pre_start got=%0h want=1", render_start); end
    reset = 1'b1;
    model_reset();
    #1;
    total++; if (render_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_async got=%0h/%0h want=0/0", render_start, busy); end
    @(negedge clk);
    total++; if (vertex_buffer_base !== 26'h300000 || MV !== '0 || irq !== 1'b0) begin
      bad++; $display("FAIL mid_reset_vals vb=%0h irq=%0h want vb=300000 irq=0 MV=0", vertex_buffer_base, irq);
    end
    reset = 1'b0;
    pulse_done();
    bus_read(16'h0010, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_fcnt got=%0h want=0", d); end
    bus_read(16'h000C, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_status got=%0h want=0", d); end
  endtask

  initial begin
    bus.address = '0; bus.writedata = '0; bus.write = 1'b0; bus.read = 1'b0;
    render_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_shadow_write();
    test_start();
    test_busy_reject();
    test_done_irq();
    test_collisions();
    test_unmapped();
    test_random(300);
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
